u_alu_arb: RTL and testbench

U_ALU_ARB -- requirements
Module: u_alu_arb

---
 rtl/u_alu_arb.sv | 165 ++++++++++++++++
 tb/tb_u_alu_arb.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/u_alu_arb.sv
// -----------------------------------------------------------------------------
// u_alu_arb -- two-requester arbiter in front of one shared combinational ALU.
//
// Each requester presents an opcode and two operands with a valid/ready
// handshake. The winning request is driven onto the ALU inputs in the
// grant cycle. The ALU result and compare flags are captured one cycle
// later into a registered response slot with its own valid/ready handshake.
//
// Build option:
//   ALU_ARB_RR_EN  defined   -> round-robin between the two requesters
//                  undefined -> fixed priority, requester 0 wins
//
// Parameter:
//   ZERO_IDLE  1 -> ALU inputs are forced to 0 in cycles with no grant
//              0 -> ALU inputs hold the last granted request
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req{0,1}_vld/_rdy             request handshake (rdy = accepted now)
//   req{0,1}_op/_i1/_i2           opcode and operands
//   alu_op/_i1/_i2                to the shared ALU
//   alu_o/_eq/_lt/_ltu            from the shared ALU
//   rsp_vld/_rdy                  response handshake
//   rsp_id                        requester that owns the response
//   rsp_o/_eq/_lt/_ltu            registered result and compare flags
// -----------------------------------------------------------------------------
module u_alu_arb #(
   parameter int ZERO_IDLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_vld,
   output logic        req0_rdy,
   input  logic [3:0]  req0_op,
   input  logic [31:0] req0_i1,
   input  logic [31:0] req0_i2,
   input  logic        req1_vld,
   output logic        req1_rdy,
   input  logic [3:0]  req1_op,
   input  logic [31:0] req1_i1,
   input  logic [31:0] req1_i2,
   output logic [3:0]  alu_op,
   output logic [31:0] alu_i1,
   output logic [31:0] alu_i2,
   input  logic [31:0] alu_o,
   input  logic        alu_eq,
   input  logic        alu_lt,
   input  logic        alu_ltu,
   output logic        rsp_vld,
   input  logic        rsp_rdy,
   output logic        rsp_id,
   output logic [31:0] rsp_o,
   output logic        rsp_eq,
   output logic        rsp_lt,
   output logic        rsp_ltu
);

   logic        can_load;  // response slot is empty or draining this cycle
   logic        pick1;     // requester 1 wins arbitration (if it can load)
   logic        acc0;
   logic        acc1;
   logic        grant;
   logic [3:0]  sel_op;
   logic [31:0] sel_i1;
   logic [31:0] sel_i2;

`ifdef ALU_ARB_RR_EN
   // Last-granted requester; resets to 1 so the first contested grant
   // goes to requester 0.
   logic last_q;
`endif

   // NOTE: every signal written here gets a value on every path (defaults
   // first), so no latch can be inferred.
   always_comb begin
      can_load = 1'b0;
      pick1    = 1'b0;
      acc0     = 1'b0;
      acc1     = 1'b0;

      can_load = !rsp_vld || rsp_rdy;
`ifdef ALU_ARB_RR_EN
      // A lone valid requester always wins; on contention the one not
      // granted last time wins.
      pick1 = req1_vld && (!req0_vld || !last_q);
`else
      pick1 = req1_vld && !req0_vld;
`endif
      // Reset blocks any accept so nothing is granted while state clears.
      acc0 = !rst && can_load && req0_vld && !pick1;
      acc1 = !rst && can_load && pick1;
   end

   assign req0_rdy = acc0;
   assign req1_rdy = acc1;
   assign grant    = acc0 || acc1;

   assign sel_op = pick1 ? req1_op : req0_op;
   assign sel_i1 = pick1 ? req1_i1 : req0_i1;
   assign sel_i2 = pick1 ? req1_i2 : req0_i2;

   generate
      if (ZERO_IDLE != 0) begin : g_zero_idle
         assign alu_op = grant ? sel_op : 4'd0;
         assign alu_i1 = grant ? sel_i1 : 32'd0;
         assign alu_i2 = grant ? sel_i2 : 32'd0;
      end else begin : g_hold_idle
         logic [3:0]  op_q;
         logic [31:0] i1_q;
         logic [31:0] i2_q;

         // NOTE: these are plain datapath holding registers; they are reset
         // only so the idle ALU inputs are deterministic after reset.
         always_ff @(posedge clk) begin
            if (rst) begin
               op_q <= 4'd0;
               i1_q <= 32'd0;
               i2_q <= 32'd0;
            end else if (grant) begin
               op_q <= sel_op;
               i1_q <= sel_i1;
               i2_q <= sel_i2;
            end
         end

         assign alu_op = grant ? sel_op : op_q;
         assign alu_i1 = grant ? sel_i1 : i1_q;
         assign alu_i2 = grant ? sel_i2 : i2_q;
      end
   endgenerate

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_vld <= 1'b0;
         rsp_id  <= 1'b0;
         rsp_o   <= 32'd0;
         rsp_eq  <= 1'b0;
         rsp_lt  <= 1'b0;
         rsp_ltu <= 1'b0;
      end else if (grant) begin
         // Covers both an empty slot and same-cycle drain and refill.
         rsp_vld <= 1'b1;
         rsp_id  <= pick1;
         rsp_o   <= alu_o;
         rsp_eq  <= alu_eq;
         rsp_lt  <= alu_lt;
         rsp_ltu <= alu_ltu;
      end else if (rsp_rdy) begin
         rsp_vld <= 1'b0;
      end
   end

`ifdef ALU_ARB_RR_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= 1'b1;
      end else if (grant) begin
         last_q <= pick1;
      end
   end
`endif

endmodule

// File: tb/tb_u_alu_arb.sv
// -----------------------------------------------------------------------------
// tb_u_alu_arb -- directed self-checking bench for u_alu_arb.
//
// A small behavioural ALU closes the loop between alu_op/alu_i1/alu_i2 and
// alu_o/flags. Inputs change on the falling edge; combinational outputs are
// checked just after that, registered outputs just after the rising edge.
// Expected arbitration results follow ALU_ARB_RR_EN if it is defined.
// -----------------------------------------------------------------------------
module tb_u_alu_arb;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_SLT = 4'h2;
   localparam logic [3:0] OP_XOR = 4'h4;
   localparam logic [3:0] OP_BAD = 4'hF;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_vld, req0_rdy;
   logic [3:0]  req0_op;
   logic [31:0] req0_i1, req0_i2;
   logic        req1_vld, req1_rdy;
   logic [3:0]  req1_op;
   logic [31:0] req1_i1, req1_i2;
   logic [3:0]  alu_op;
   logic [31:0] alu_i1, alu_i2;
   logic [31:0] alu_o;
   logic        alu_eq, alu_lt, alu_ltu;
   logic        rsp_vld, rsp_rdy, rsp_id;
   logic [31:0] rsp_o;
   logic        rsp_eq, rsp_lt, rsp_ltu;

   int n_checks = 0;
   int n_errors = 0;

`ifdef ALU_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   always #5 clk = ~clk;

   u_alu_arb dut (
      .clk      (clk),
      .rst      (rst),
      .req0_vld (req0_vld),
      .req0_rdy (req0_rdy),
      .req0_op  (req0_op),
      .req0_i1  (req0_i1),
      .req0_i2  (req0_i2),
      .req1_vld (req1_vld),
      .req1_rdy (req1_rdy),
      .req1_op  (req1_op),
      .req1_i1  (req1_i1),
      .req1_i2  (req1_i2),
      .alu_op   (alu_op),
      .alu_i1   (alu_i1),
      .alu_i2   (alu_i2),
      .alu_o    (alu_o),
      .alu_eq   (alu_eq),
      .alu_lt   (alu_lt),
      .alu_ltu  (alu_ltu),
      .rsp_vld  (rsp_vld),
      .rsp_rdy  (rsp_rdy),
      .rsp_id   (rsp_id),
      .rsp_o    (rsp_o),
      .rsp_eq   (rsp_eq),
      .rsp_lt   (rsp_lt),
      .rsp_ltu  (rsp_ltu)
   );

   // Behavioural shared ALU; undefined opcodes return 0.
   always_comb begin
      alu_o   = 32'd0;
      alu_eq  = (alu_i1 == alu_i2);
      alu_lt  = ($signed(alu_i1) < $signed(alu_i2));
      alu_ltu = (alu_i1 < alu_i2);
      case (alu_op)
         OP_ADD:  alu_o = alu_i1 + alu_i2;
         OP_SUB:  alu_o = alu_i1 - alu_i2;
         OP_SLT:  alu_o = {31'd0, alu_lt};
         OP_XOR:  alu_o = alu_i1 ^ alu_i2;
         default: alu_o = 32'd0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive0(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      req0_vld = v; req0_op = op; req0_i1 = a; req0_i2 = b;
   endtask

   task automatic drive1(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      req1_vld = v; req1_op = op; req1_i1 = a; req1_i2 = b;
   endtask

   // Move to the falling edge and let combinational outputs settle.
   task automatic to_neg();
      @(negedge clk);
   endtask

   task automatic settle();
      #1;
   endtask

   // Cross the rising edge and sample registered outputs.
   task automatic to_pos();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic exp_id;
      logic [31:0] exp_o;

      rst = 1'b1;
      rsp_rdy = 1'b1;
      drive0(1'b1, OP_ADD, 32'd1, 32'd1);
      drive1(1'b0, OP_ADD, 32'd0, 32'd0);

      // Reset state; a valid request must not be accepted during reset.
      to_neg(); settle();
      check("rst_req0_rdy", req0_rdy, 1'b0);
      to_pos();
      to_neg(); settle();
      check("rst_rsp_vld", rsp_vld, 1'b0);
      check("rst_rsp_id",  rsp_id,  1'b0);
      check("rst_rsp_o",   rsp_o,   32'd0);
      check("rst_flags",   {rsp_eq, rsp_lt, rsp_ltu}, 3'b000);
      check("rst_req0_rdy2", req0_rdy, 1'b0);

      // Single ADD 5+3 from requester 0, one-cycle latency.
      rst = 1'b0;
      drive0(1'b1, OP_ADD, 32'd5, 32'd3);
      settle();
      check("add_req0_rdy", req0_rdy, 1'b1);
      check("add_req1_rdy", req1_rdy, 1'b0);
      check("add_alu_i1",   alu_i1,   32'd5);
      check("add_alu_i2",   alu_i2,   32'd3);
      to_pos();
      check("add_rsp_vld", rsp_vld, 1'b1);
      check("add_rsp_id",  rsp_id,  1'b0);
      check("add_rsp_o",   rsp_o,   32'd8);

      // Idle cycle: response drains, ALU inputs forced to zero.
      to_neg();
      drive0(1'b0, OP_ADD, 32'd9, 32'd9);
      settle();
      check("idle_rdy",    {req0_rdy, req1_rdy}, 2'b00);
      check("idle_alu_op", alu_op, 4'd0);
      check("idle_alu_i1", alu_i1, 32'd0);
      to_pos();
      check("idle_rsp_vld", rsp_vld, 1'b0);

      // Lone requester 1 with an undefined opcode and equal operands.
      to_neg();
      drive1(1'b1, OP_BAD, 32'd7, 32'd7);
      settle();
      check("bad_req1_rdy", req1_rdy, 1'b1);
      check("bad_alu_op",   alu_op,   OP_BAD);
      to_pos();
      check("bad_rsp_id", rsp_id, 1'b1);
      check("bad_rsp_o",  rsp_o,  32'd0);
      check("bad_rsp_eq", rsp_eq, 1'b1);

      // Contention for four cycles: SUB 10-4 vs SLT -1 < 1.
      to_neg();
      drive0(1'b1, OP_SUB, 32'd10, 32'd4);
      drive1(1'b1, OP_SLT, 32'hFFFF_FFFF, 32'd1);
      for (int k = 0; k < 4; k++) begin
         exp_id = RR ? k[0] : 1'b0;
         exp_o  = exp_id ? 32'd1 : 32'd6;
         settle();
         check($sformatf("con%0d_rdy", k), {req1_rdy, req0_rdy}, exp_id ? 2'b10 : 2'b01);
         to_pos();
         check($sformatf("con%0d_rsp_vld", k), rsp_vld, 1'b1);
         check($sformatf("con%0d_rsp_id", k),  rsp_id,  exp_id);
         check($sformatf("con%0d_rsp_o", k),   rsp_o,   exp_o);
         check($sformatf("con%0d_rsp_lt", k),  rsp_lt,  exp_id);
         to_neg();
      end

      // XOR 0xF0 ^ 0x0F from requester 0, then backpressure.
      drive0(1'b1, OP_XOR, 32'h0000_00F0, 32'h0000_000F);
      drive1(1'b0, OP_ADD, 32'd0, 32'd0);
      settle();
      check("xor_req0_rdy", req0_rdy, 1'b1);
      to_pos();
      check("xor_rsp_o", rsp_o, 32'h0000_00FF);

      to_neg();
      rsp_rdy = 1'b0;
      drive0(1'b1, OP_ADD, 32'd1, 32'd1);
      drive1(1'b1, OP_ADD, 32'd2, 32'd2);
      for (int k = 0; k < 3; k++) begin
         settle();
         check($sformatf("bp%0d_rdy", k),    {req0_rdy, req1_rdy}, 2'b00);
         check($sformatf("bp%0d_alu_op", k), {alu_op, alu_i1[3:0]}, 8'h00);
         to_pos();
         check($sformatf("bp%0d_rsp_vld", k), rsp_vld, 1'b1);
         check($sformatf("bp%0d_rsp_o", k),   rsp_o,   32'h0000_00FF);
         check($sformatf("bp%0d_rsp_id", k),  rsp_id,  1'b0);
         to_neg();
      end

      // Release: drain and refill in the same cycle. Requester 0 was last
      // granted, so round-robin hands this one to requester 1.
      rsp_rdy = 1'b1;
      exp_id = RR ? 1'b1 : 1'b0;
      settle();
      check("rel_rdy", {req1_rdy, req0_rdy}, exp_id ? 2'b10 : 2'b01);
      to_pos();
      check("rel_rsp_vld", rsp_vld, 1'b1);
      check("rel_rsp_id",  rsp_id,  exp_id);
      check("rel_rsp_o",   rsp_o,   exp_id ? 32'd4 : 32'd2);

      // Reset with a response pending discards it.
      to_neg();
      rst = 1'b1;
      rsp_rdy = 1'b0;
      settle();
      check("rst2_rdy", {req0_rdy, req1_rdy}, 2'b00);
      to_pos();
      check("rst2_rsp_vld", rsp_vld, 1'b0);
      check("rst2_rsp_o",   rsp_o,   32'd0);

      // First contested grant after reset goes to requester 0.
      to_neg();
      rst = 1'b0;
      rsp_rdy = 1'b1;
      settle();
      check("post_rdy", {req1_rdy, req0_rdy}, 2'b01);
      to_pos();
      check("post_rsp_id", rsp_id, 1'b0);
      check("post_rsp_o",  rsp_o,  32'd2);

      to_neg();
      drive0(1'b0, OP_ADD, 32'd0, 32'd0);
      drive1(1'b0, OP_ADD, 32'd0, 32'd0);
      to_pos();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
